// File: rtl/gecko_print_arbiter.sv
// Merges per-core 8-bit print streams into one tagged byte stream through per-channel FIFOs,
// a round-robin (optionally line-atomic) arbiter and a registered output stage; also keeps sticky core status.
module gecko_print_arbiter #(
    parameter int NUM_CHANNELS = 4,
    parameter int FIFO_DEPTH   = 16,
    parameter int ID_WIDTH     = 2,
    parameter int LINE_MODE    = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CHANNELS-1:0]   in_valid,
    output logic [NUM_CHANNELS-1:0]   in_ready,
    input  logic [8*NUM_CHANNELS-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [7:0]                out_data,
    output logic [ID_WIDTH-1:0]       out_id,
    input  logic [NUM_CHANNELS-1:0]   faulted_flags,
    input  logic [NUM_CHANNELS-1:0]   finished_flags,
    input  logic                      status_clear,
    output logic [NUM_CHANNELS-1:0]   fault_sticky,
    output logic                      any_faulted,
    output logic                      all_finished
);

    localparam int SEL_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CHANNELS - 1);
    localparam logic [7:0]       NEWLINE  = 8'h0A;

    logic [7:0]              r_mem   [NUM_CHANNELS][FIFO_DEPTH];
    logic [PTR_W-1:0]        r_wptr  [NUM_CHANNELS];
    logic [PTR_W-1:0]        r_rptr  [NUM_CHANNELS];
    logic [CNT_W-1:0]        r_count [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] w_push;
    logic [NUM_CHANNELS-1:0] w_pop;
    logic [NUM_CHANNELS-1:0] w_nonempty;
    logic [SEL_W-1:0]        r_rr_ptr;
    logic [SEL_W-1:0]        r_lock_ch;
    logic                    r_locked;
    logic [SEL_W-1:0]        w_sel;
    logic [SEL_W-1:0]        w_cand;
    logic                    w_found;
    logic                    w_load;
    logic [7:0]              w_rd_data;
    logic                    r_out_valid;
    logic [7:0]              r_out_data;
    logic [ID_WIDTH-1:0]     r_out_id;
    logic [NUM_CHANNELS-1:0] r_fault_sticky;

    // Ready looks only at the registered count, so a pop in the same cycle never frees a slot early.
    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            w_nonempty[c] = (r_count[c] != '0);
            in_ready[c]   = !rst && (r_count[c] != FULL_CNT);
            w_push[c]     = in_valid[c] && in_ready[c];
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        if ((LINE_MODE != 0) && r_locked) begin
            w_found = w_nonempty[r_lock_ch];
            w_sel   = r_lock_ch;
        end else begin
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                w_cand = SEL_W'((int'(r_rr_ptr) + k) % NUM_CHANNELS);
                if (!w_found && w_nonempty[w_cand]) begin
                    w_found = 1'b1;
                    w_sel   = w_cand;
                end
            end
        end
        w_load       = w_found && (!r_out_valid || out_ready);
        w_pop        = '0;
        w_pop[w_sel] = w_load;
        w_rd_data    = r_mem[w_sel][r_rptr[w_sel]];
    end

    // NOTE: FIFO storage has no reset; emptiness is defined by the pointers and counts alone.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (w_push[c]) r_mem[c][r_wptr[c]] <= in_data[8*c +: 8];
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_wptr[c]  <= '0;
                r_rptr[c]  <= '0;
                r_count[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (w_push[c]) r_wptr[c] <= r_wptr[c] + 1'b1;
                if (w_pop[c])  r_rptr[c] <= r_rptr[c] + 1'b1;
                if (w_push[c] && !w_pop[c])      r_count[c] <= r_count[c] + 1'b1;
                else if (!w_push[c] && w_pop[c]) r_count[c] <= r_count[c] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= '0;
            r_rr_ptr    <= '0;
            r_lock_ch   <= '0;
            r_locked    <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_rd_data;
            r_out_id    <= ID_WIDTH'(w_sel);
            r_rr_ptr    <= (w_sel == LAST_CH) ? '0 : w_sel + 1'b1;
            r_lock_ch   <= w_sel;
            r_locked    <= (LINE_MODE != 0) && (w_rd_data != NEWLINE);
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // A fault seen in the same cycle as a clear must survive the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_fault_sticky <= '0;
        else     r_fault_sticky <= (r_fault_sticky & ~{NUM_CHANNELS{status_clear}}) | faulted_flags;
    end

    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_id       = r_out_id;
    assign fault_sticky = r_fault_sticky;
    assign any_faulted  = |r_fault_sticky;
    assign all_finished = (&finished_flags) && !(|w_nonempty) && !r_out_valid;

endmodule

// File: tb/tb_gecko_print_arbiter.sv
// Directed bench for gecko_print_arbiter: a byte-stream instance and a line-atomic instance.
module tb_gecko_print_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  in_valid, in_ready, l_in_valid, l_in_ready;
    logic [31:0] in_data, l_in_data;
    logic        out_valid, out_ready, l_out_valid, l_out_ready;
    logic [7:0]  out_data, l_out_data;
    logic [1:0]  out_id, l_out_id;
    logic [3:0]  faulted_flags, finished_flags, fault_sticky, l_fault_sticky;
    logic        status_clear, any_faulted, all_finished, l_any_faulted, l_all_finished;

    gecko_print_arbiter #(.NUM_CHANNELS(4), .FIFO_DEPTH(16), .ID_WIDTH(2), .LINE_MODE(0)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
        .faulted_flags(faulted_flags), .finished_flags(finished_flags), .status_clear(status_clear),
        .fault_sticky(fault_sticky), .any_faulted(any_faulted), .all_finished(all_finished)
    );

    gecko_print_arbiter #(.NUM_CHANNELS(4), .FIFO_DEPTH(16), .ID_WIDTH(2), .LINE_MODE(1)) dut_line (
        .clk(clk), .rst(rst),
        .in_valid(l_in_valid), .in_ready(l_in_ready), .in_data(l_in_data),
        .out_valid(l_out_valid), .out_ready(l_out_ready), .out_data(l_out_data), .out_id(l_out_id),
        .faulted_flags(faulted_flags), .finished_flags(finished_flags), .status_clear(status_clear),
        .fault_sticky(l_fault_sticky), .any_faulted(l_any_faulted), .all_finished(l_all_finished)
    );

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic        rdy;
        logic        exp_v;
        logic [1:0]  exp_id;
        logic [7:0]  exp_d;
    } vec_t;

    vec_t vec [15];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = '0; in_data = '0; out_ready = 1'b0;
        l_in_valid = '0; l_in_data = '0; l_out_ready = 1'b0;
        faulted_flags = '0; finished_flags = '0; status_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [9:0] got_q [$];
    logic [9:0] exp_line [6];
    int         acc, got;
    logic       saw_valid;

    initial begin
        // Round robin from channel 0 after reset, one backpressure hold, then a lone channel.
        vec[0]  = '{4'hF, 32'h31211101, 1'b1, 1'b0, 2'd0, 8'h00};
        vec[1]  = '{4'hF, 32'h32221202, 1'b1, 1'b1, 2'd0, 8'h01};
        vec[2]  = '{4'h0, 32'h0,        1'b1, 1'b1, 2'd1, 8'h11};
        vec[3]  = '{4'h0, 32'h0,        1'b0, 1'b1, 2'd1, 8'h11};
        vec[4]  = '{4'h0, 32'h0,        1'b1, 1'b1, 2'd2, 8'h21};
        vec[5]  = '{4'h0, 32'h0,        1'b1, 1'b1, 2'd3, 8'h31};
        vec[6]  = '{4'h0, 32'h0,        1'b1, 1'b1, 2'd0, 8'h02};
        vec[7]  = '{4'h0, 32'h0,        1'b1, 1'b1, 2'd1, 8'h12};
        vec[8]  = '{4'h0, 32'h0,        1'b1, 1'b1, 2'd2, 8'h22};
        vec[9]  = '{4'h0, 32'h0,        1'b1, 1'b1, 2'd3, 8'h32};
        vec[10] = '{4'h0, 32'h0,        1'b1, 1'b0, 2'd0, 8'h00};
        vec[11] = '{4'h4, 32'h00A50000, 1'b1, 1'b0, 2'd0, 8'h00};
        vec[12] = '{4'h4, 32'h00A60000, 1'b1, 1'b1, 2'd2, 8'hA5};
        vec[13] = '{4'h0, 32'h0,        1'b1, 1'b1, 2'd2, 8'hA6};
        vec[14] = '{4'h0, 32'h0,        1'b1, 1'b0, 2'd0, 8'h00};

        exp_line[0] = {2'd1, 8'h61};
        exp_line[1] = {2'd1, 8'h62};
        exp_line[2] = {2'd1, 8'h0A};
        exp_line[3] = {2'd2, 8'h63};
        exp_line[4] = {2'd2, 8'h64};
        exp_line[5] = {2'd2, 8'h0A};

        // Reset state and first-byte latency
        do_reset();
        check("rst_in_ready", in_ready, 4'hF);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_out_id", out_id, 2'd0);
        check("rst_fault", fault_sticky, 4'h0);
        in_valid = 4'h1; in_data = 32'h41; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = '0;
        check("lat_t_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        check("lat_t1_valid", out_valid, 1'b1);
        check("lat_t1_data", out_data, 8'h41);
        check("lat_t1_id", out_id, 2'd0);

        // Table-driven round robin
        do_reset();
        for (int i = 0; i < 15; i++) begin
            in_valid = vec[i].valid; in_data = vec[i].data; out_ready = vec[i].rdy;
            @(posedge clk); #1;
            check($sformatf("vec%0d_valid", i), out_valid, vec[i].exp_v);
            if (vec[i].exp_v) begin
                check($sformatf("vec%0d_id", i), out_id, vec[i].exp_id);
                check($sformatf("vec%0d_data", i), out_data, vec[i].exp_d);
            end
        end
        in_valid = '0;

        // Line-atomic: ch1 holds the grant while empty until its newline
        do_reset();
        l_out_ready = 1'b1;
        got_q.delete();
        for (int i = 0; i < 16; i++) begin
            case (i)
                0: begin l_in_valid = 4'b0010; l_in_data = 32'h00006100; end
                1: begin l_in_valid = 4'b0110; l_in_data = 32'h00636200; end
                2: begin l_in_valid = 4'b0100; l_in_data = 32'h00640000; end
                3: begin l_in_valid = 4'b0100; l_in_data = 32'h000A0000; end
                5: begin l_in_valid = 4'b0010; l_in_data = 32'h00000A00; end
                default: begin l_in_valid = '0; l_in_data = '0; end
            endcase
            @(posedge clk); #1;
            if (i == 3) check("line_idle_locked", l_out_valid, 1'b0);
            if (l_out_valid) got_q.push_back({l_out_id, l_out_data});
        end
        l_in_valid = '0;
        check("line_count", got_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < got_q.size()) check($sformatf("line_byte%0d", i), got_q[i], exp_line[i]);
        end

        // Backpressure: 16 FIFO entries plus the output register
        do_reset();
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 24 && in_ready[3]; i++) begin
            in_valid = 4'b1000;
            in_data  = {8'hC0 + 8'(acc), 24'h0};
            @(posedge clk);
            acc++;
            #1;
        end
        in_valid = '0;
        check("full_accepted", acc, 17);
        check("full_in_ready3", in_ready[3], 1'b0);
        check("full_hold_data", out_data, 8'hC0);
        out_ready = 1'b1;
        got = 0;
        for (int i = 0; i < 40 && got < 17; i++) begin
            if (out_valid) begin
                check($sformatf("drain%0d", got), {out_id, out_data}, {2'd3, 8'hC0 + 8'(got)});
                got++;
            end
            @(posedge clk); #1;
        end
        check("drain_count", got, 17);
        check("drain_empty", out_valid, 1'b0);

        // Sticky fault: set wins over a coincident clear
        do_reset();
        faulted_flags = 4'b0100;
        @(posedge clk); #1;
        faulted_flags = '0;
        check("fault_set", fault_sticky, 4'b0100);
        check("fault_any", any_faulted, 1'b1);
        @(posedge clk); #1;
        check("fault_hold", fault_sticky, 4'b0100);
        faulted_flags = 4'b0100; status_clear = 1'b1;
        @(posedge clk); #1;
        faulted_flags = '0; status_clear = 1'b0;
        check("fault_set_wins", fault_sticky, 4'b0100);
        status_clear = 1'b1;
        @(posedge clk); #1;
        status_clear = 1'b0;
        check("fault_cleared", fault_sticky, 4'b0000);
        check("fault_any_clr", any_faulted, 1'b0);

        // all_finished waits for the last byte to handshake
        do_reset();
        finished_flags = 4'hF;
        #1 check("fin_idle", all_finished, 1'b1);
        out_ready = 1'b0;
        in_valid = 4'h1; in_data = 32'h55;
        @(posedge clk); #1;
        in_valid = '0;
        check("fin_fifo_pending", all_finished, 1'b0);
        @(posedge clk); #1;
        check("fin_out_valid", out_valid, 1'b1);
        check("fin_out_pending", all_finished, 1'b0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("fin_drained_valid", out_valid, 1'b0);
        check("fin_drained", all_finished, 1'b1);
        finished_flags = 4'hE;
        #1 check("fin_partial", all_finished, 1'b0);
        finished_flags = 4'hF;

        // Asynchronous reset in the middle of a stream
        out_ready = 1'b0;
        in_valid = 4'b0011; in_data = 32'h00006677;
        repeat (3) @(posedge clk);
        #1 in_valid = '0;
        check("mid_pre_valid", out_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_ready", in_ready, 4'h0);
        check("mid_rst_empty", all_finished, 1'b1);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        check("mid_post_ready", in_ready, 4'hF);
        out_ready = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (out_valid) saw_valid = 1'b1;
        end
        check("mid_fifos_empty", saw_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
